// File: rtl/disp_msg_seq.sv
// Bulls/cows game message sequencer: drives 8 registered display words and the try count.
// Optional text blinking in the IDLE and WIN frames when DSPL_BLINK_EN is defined.
module disp_msg_seq #(
  parameter int TICK_COUNT = 100000,
  parameter int BLINK_MS   = 250,
  parameter int MAX_TRIES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       res_valid,
  input  logic [2:0] bulls,
  input  logic [2:0] cows,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic [3:0] tries,
  output logic       bad_res
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  localparam logic [5:0] BLANK = 6'b0_1111_1;
  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  localparam logic [3:0] G_0 = 4'h0;
  localparam logic [3:0] G_Y = 4'h4;
  localparam logic [3:0] G_S = 4'h5;
  localparam logic [3:0] G_T = 4'h7;
  localparam logic [3:0] G_B = 4'h8;
  localparam logic [3:0] G_L = 4'h9;
  localparam logic [3:0] G_A = 4'hA;
  localparam logic [3:0] G_U = 4'hC;
  localparam logic [3:0] G_P = 4'hD;
  localparam logic [3:0] G_E = 4'hE;

  state_t          state_q, state_d;
  logic [3:0]      tries_q, tries_d;
  logic [2:0]      bulls_q, bulls_d;
  logic [2:0]      cows_q, cows_d;
  logic            bad_res_q, bad_res_d;
  logic [7:0][5:0] disp_q, disp_d;
  logic            vis_d;

  logic [3:0] tries_inc;
  logic       res_ok;

  function automatic logic [5:0] glyph(input logic [3:0] code);
    return {1'b1, code, 1'b1};
  endfunction

  // Text glyph whose enable follows the blink phase.
  function automatic logic [5:0] text(input logic [3:0] code, input logic vis);
    return {vis, code, 1'b1};
  endfunction

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    bulls_d   = bulls_q;
    cows_d    = cows_q;
    bad_res_d = 1'b0;
    tries_inc = tries_q + 4'd1;
    res_ok    = (bulls <= 3'd4) && (cows <= 3'd4) &&
                (({1'b0, bulls} + {1'b0, cows}) <= 4'd4);

    if (new_game) begin
      state_d = PLAY;
      tries_d = 4'd0;
      bulls_d = 3'd0;
      cows_d  = 3'd0;
    end else if (res_valid && (state_q == PLAY)) begin
      if (res_ok) begin
        bulls_d = bulls;
        cows_d  = cows;
        tries_d = tries_inc;
        if (bulls == 3'd4) begin
          state_d = WIN;
        end else if (tries_inc == MAX_T) begin
          state_d = LOSE;
        end
      end else begin
        bad_res_d = 1'b1;
      end
    end
  end

`ifdef DSPL_BLINK_EN
  localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int MW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  logic [TW-1:0] tick_q, tick_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          vis_q;
  logic          ms_tick;
  logic          restart;

  always_comb begin
    tick_d  = tick_q;
    ms_d    = ms_q;
    vis_d   = vis_q;
    ms_tick = (tick_q == TW'(TICK_COUNT - 1));
    restart = (state_d != state_q) && ((state_d == IDLE) || (state_d == WIN));

    if (restart) begin
      tick_d = '0;
      ms_d   = '0;
      vis_d  = 1'b1;
    end else begin
      tick_d = ms_tick ? '0 : tick_q + TW'(1);
      if (ms_tick) begin
        if (ms_q == MW'(BLINK_MS - 1)) begin
          ms_d  = '0;
          vis_d = ~vis_q;
        end else begin
          ms_d = ms_q + MW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
      ms_q   <= '0;
      vis_q  <= 1'b1;
    end else begin
      tick_q <= tick_d;
      ms_q   <= ms_d;
      vis_q  <= vis_d;
    end
  end
`else
  always_comb vis_d = 1'b1;
`endif

  // Frame is built from next-state values so it lands on the same edge as the event.
  always_comb begin
    disp_d = {8{BLANK}};
    case (state_d)
      IDLE: begin
        disp_d[7] = text(G_P, vis_d);
        disp_d[6] = text(G_L, vis_d);
        disp_d[5] = text(G_A, vis_d);
        disp_d[4] = text(G_Y, vis_d);
      end
      PLAY: begin
        disp_d[7] = {1'b1, 1'b0, bulls_d, 1'b0};
        disp_d[6] = glyph(G_B);
        disp_d[4] = glyph({1'b0, cows_d});
        disp_d[3] = glyph(G_U);
        disp_d[0] = glyph(tries_d);
      end
      WIN: begin
        disp_d[7] = text(G_Y, vis_d);
        disp_d[6] = text(G_E, vis_d);
        disp_d[5] = text(G_S, vis_d);
        disp_d[0] = glyph(tries_d);
      end
      LOSE: begin
        disp_d[7] = glyph(G_L);
        disp_d[6] = glyph(G_0);
        disp_d[5] = glyph(G_S);
        disp_d[4] = glyph(G_T);
        disp_d[0] = glyph(tries_d);
      end
      default: disp_d = {8{BLANK}};
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tries_q   <= 4'd0;
      bulls_q   <= 3'd0;
      cows_q    <= 3'd0;
      bad_res_q <= 1'b0;
      disp_q    <= {8{BLANK}};
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      bulls_q   <= bulls_d;
      cows_q    <= cows_d;
      bad_res_q <= bad_res_d;
      disp_q    <= disp_d;
    end
  end

  assign d1      = disp_q[0];
  assign d2      = disp_q[1];
  assign d3      = disp_q[2];
  assign d4      = disp_q[3];
  assign d5      = disp_q[4];
  assign d6      = disp_q[5];
  assign d7      = disp_q[6];
  assign d8      = disp_q[7];
  assign tries   = tries_q;
  assign bad_res = bad_res_q;

endmodule

// File: doc/disp_msg_seq.md
DISP_MSG_SEQ -- requirements
Module: disp_msg_seq

Interface
REQ-001 SHALL have parameter TICK_COUNT, default 100000, meaning clock cycles per 1 ms tick.
REQ-002 SHALL have parameter BLINK_MS, default 250, meaning ms per blink half-period.
REQ-003 SHALL have parameter MAX_TRIES, default 8, legal range 1..8, meaning guesses allowed per game.
REQ-004 SHALL have port clock  input  1  system clock, rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port new_game  input  1  one-cycle pulse that starts or restarts a game.
REQ-007 SHALL have port res_valid  input  1  one-cycle pulse meaning bulls/cows are valid.
REQ-008 SHALL have ports bulls, cows  input  3 each  guess score, 0..4.
REQ-009 SHALL have ports d1..d8  output  6 each  registered digit words {en, code[3:0], dp_n} for the 8-digit display driver.
REQ-010 SHALL have port tries  output  4  guesses taken in the current game.
REQ-011 SHALL have port bad_res  output  1  one-cycle pulse on a rejected result.

Function
REQ-012 Blank word SHALL be 6'b0_1111_1; lit glyph SHALL use en=1 and dp_n=1 unless stated otherwise.
REQ-013 Glyph codes SHALL be: 0-8 digits; 4=Y, 5=S, 7=T, 8=B, 9=L, A=A, C=U, D=P, E=E.
REQ-014 FSM states SHALL be IDLE, PLAY, WIN, LOSE.
REQ-015 IDLE frame SHALL be d8..d5="P","L","A","Y"; all other digits blank.
REQ-016 PLAY frame SHALL be: d8=last bulls with dp_n=0; d7=8; d5=last cows; d4=C; d1=tries; all other digits blank.
REQ-017 WIN frame SHALL be d8..d6="Y","E","S", d1=tries, others blank.
REQ-018 LOSE frame SHALL be d8..d5="L","0","S","T", d1=tries, others blank.
REQ-019 new_game in any state SHALL enter PLAY, clear tries, and clear the latched bulls/cows to 0.
REQ-020 In PLAY, res_valid with bulls+cows<=4 SHALL latch bulls/cows and increment tries.
REQ-021 An accepted result with bulls==4 SHALL enter WIN; otherwise, if the incremented tries==MAX_TRIES it SHALL enter LOSE; otherwise the FSM SHALL remain in PLAY.
REQ-022 In PLAY, res_valid with bulls+cows>4 or either value >4 SHALL be ignored, and bad_res SHALL pulse on the next cycle.
REQ-023 res_valid in IDLE, WIN or LOSE SHALL be ignored, with no bad_res pulse.
REQ-024 When new_game and res_valid occur in the same cycle, new_game SHALL take priority and the result SHALL be dropped.
REQ-025 d1..d8 and tries SHALL reflect an event on the first rising edge after the event cycle (latency 1).
REQ-026 A free-running ms tick SHALL fire every TICK_COUNT cycles, and the blink phase SHALL toggle every BLINK_MS ticks.
REQ-027 On entry to IDLE or WIN, the blink phase SHALL reset to visible and the ms counters SHALL clear.

Reset
REQ-028 reset SHALL force state IDLE, all d1..d8 blank, tries=0, bad_res=0, latched bulls/cows=0, blink phase visible, and all counters=0.
REQ-029 reset asserted mid-game SHALL discard all game state, and the first frame after release SHALL be the IDLE frame.

Configuration
REQ-030 With DSPL_BLINK_EN defined, the en bits of the text glyphs in the IDLE and WIN frames SHALL be forced to 0 during the invisible blink phase; d1 SHALL never blink.
REQ-031 Without DSPL_BLINK_EN, all frames SHALL be steady, and the blink and ms-tick counters SHALL be omitted from the design.

Verification (TICK_COUNT=4, BLINK_MS=2, MAX_TRIES=3)
REQ-032 Release reset -> d8..d5 = 6'h3B,6'h33,6'h35,6'h29 ("PLAY"); d4..d1 = 6'h1F.
REQ-033 new_game, then res_valid with bulls=1, cows=2 -> one cycle later d8=6'h22, d7=6'h31, d5=6'h25, d4=6'h39, d1=6'h23, tries=1.
REQ-034 new_game, then res_valid with bulls=4, cows=0 -> WIN frame, tries=1; with DSPL_BLINK_EN, d8 en toggles every 8 cycles.
REQ-035 Three results of bulls=0, cows=1 -> after the third, LOSE frame "LOST" with d1=3; a fourth res_valid leaves the outputs unchanged.
REQ-036 res_valid with bulls=3, cows=3 in PLAY -> bad_res=1 for exactly 1 cycle, tries unchanged; new_game together with res_valid (bulls=4) -> PLAY with tries=0.
